pipe_hazard_ctrl: RTL
=====================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Parametrised pipeline sequencer for the 5-stage core. Tracks per-stage valid/dest/ctrl state
//  for ID/EX, EX/MEM and MEM/WB. Generates operand-forwarding selects, load-use stalls,
//  multi-cycle-load freezes, branch flushes and the halt-drain sequence. Sits beside the
//  datapath pipeline registers and drives their hold/bubble/flush enables.
// PARAMETERS
//  REG_AW   4  register-address width (2**REG_AW registers)
//  LOAD_LAT 1  data-memory read latency in cycles, >=1; a load occupies MEM for LOAD_LAT cycles
//  ZERO_REG 1  1: register 0 is hard-wired zero; it never forwards or causes a stall
// PORTS
//  clk          in   1       clock
//  rst          in   1       one clock; reset is synchronous and active-high
//  id_valid     in   1       instruction in ID is valid
//  id_rs        in   REG_AW  ID source A address
//  id_rs_used   in   1       ID instruction reads rs
//  id_rt        in   REG_AW  ID source B address
//  id_rt_used   in   1       ID instruction reads rt
//  id_rd        in   REG_AW  ID destination address
//  id_we        in   1       ID instruction writes rd
//  id_load      in   1       ID instruction is a load
//  id_hlt       in   1       ID instruction is HLT
//  br_taken     in   1       branch in EX resolved taken this cycle
//  pc_hold      out  1       hold PC and IF/ID register
//  ifid_flush   out  1       clear IF/ID to a bubble on next edge
//  idex_bubble  out  1       load a bubble into ID/EX on next edge
//  fwd_a        out  2       EX operand A source: 00 regfile, 01 EX/MEM, 10 MEM/WB
//  fwd_b        out  2       EX operand B source, same encoding
//  ex_valid, mem_valid, wb_valid  out 1 each  stage occupancy
//  wb_rd        out  REG_AW  write-back destination
//  wb_we        out  1       write-back enable (wb_valid & write)
//  hlt          out  1       core halted, sticky until rst
// BEHAVIOUR
//  - Reset: all stage valids 0, fwd_a/fwd_b 00, hlt 0, freeze counter 0, FSM RUN; all outputs 0.
//  - Stage record {valid,rs,rs_used,rt,rt_used,rd,we,load,hlt}; ID->EX->MEM->WB each edge unless held.
//  - Match(x,s): s.valid & s.we & s.rd==x & !(ZERO_REG & x==0).
//  - fwd_a (comb., instr in EX): 01 if Match(ex.rs,MEM) & !mem.load; else 10 if Match(ex.rs,WB);
//    else 00; only when ex.rs_used, else 00. fwd_b identical on rt. EX/MEM wins over MEM/WB.
//  - Load-use: ex.load & (Match(id_rs,EX)&id_rs_used | Match(id_rt,EX)&id_rt_used) & id_valid
//    -> pc_hold=1, idex_bubble=1 for exactly one cycle; EX->MEM->WB advance normally.
//  - Freeze: load entering MEM loads counter with LOAD_LAT-1; while counter!=0: pc_hold=1,
//    IF/ID/EX/MEM all hold, WB receives bubble, counter decrements. LOAD_LAT=1 -> never freezes.
//  - Branch: br_taken sampled only when not frozen. Next edge: ifid_flush=1, idex_bubble=1
//    (kills IF and ID). Branch flush overrides a coincident load-use stall (no pc_hold).
//  - FSM RUN/DRAIN/HALTED. RUN->DRAIN when valid HLT advances ID->EX. DRAIN: pc_hold=1,
//    idex_bubble=1 every cycle. DRAIN->HALTED on edge where WB holds valid HLT; hlt=1 from then.
//    HALTED: pc_hold=1, all stages bubble, stays until rst. HLT in ID killed by branch: stay RUN.
//    HLT held in ID by load-use stall is not accepted until it advances.
//  - wb_we = wb_valid & wb.we & !(ZERO_REG & wb_rd==0).
//  - rst asserted in any state/freeze clears everything on that edge; no partial drain.
// TESTING
//  1 ADD r3<-..; ADD ..<-r3(rs); SUB ..<-r3(rt) -> I2 in EX: fwd_a=01; I3 in EX: fwd_b=10.
//  2 LW r5; ADD ..<-r5 (LOAD_LAT=1) -> pc_hold=1,idex_bubble=1 one cycle; ADD in EX: fwd_a=10.
//  3 ADD r0<-..; ADD ..<-r0 -> fwd_a=00, no stall; wb_we=0 for first instr.
//  4 LOAD_LAT=3, LW reaches MEM -> pc_hold=1 two cycles, wb_valid=0 two cycles, then LW retires.
//  5 br_taken=1 same cycle as load-use condition -> ifid_flush=1, idex_bubble=1, pc_hold=0,
//    ex_valid=0 next cycle.
//  6 ADD; ADD; HLT -> pc_hold from HLT entering EX; hlt=1 the cycle after HLT in WB; rst
//    during DRAIN -> hlt=0, all valids 0, pc_hold=0 next cycle.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline sequencer: forwarding selects, load-use stall, load freeze, branch flush, halt drain
module pipe_hazard_ctrl #(
  parameter int REG_AW   = 4,
  parameter int LOAD_LAT = 1,
  parameter bit ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic              id_rs_used,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_rt_used,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_we,
  input  logic              id_load,
  input  logic              id_hlt,
  input  logic              br_taken,
  output logic              pc_hold,
  output logic              ifid_flush,
  output logic              idex_bubble,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              ex_valid,
  output logic              mem_valid,
  output logic              wb_valid,
  output logic [REG_AW-1:0] wb_rd,
  output logic              wb_we,
  output logic              hlt
);

  localparam int CW = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;
  localparam logic [CW-1:0] FRZ_INIT = CW'(LOAD_LAT - 1);

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HALTED} state_t;

  state_t            r_state;
  logic [CW-1:0]     r_frz_cnt;
  logic              r_hlt;

  logic              r_ex_valid, r_ex_rs_used, r_ex_rt_used, r_ex_we, r_ex_load, r_ex_hlt;
  logic [REG_AW-1:0] r_ex_rs, r_ex_rt, r_ex_rd;
  logic              r_mem_valid, r_mem_we, r_mem_load, r_mem_hlt;
  logic [REG_AW-1:0] r_mem_rd;
  logic              r_wb_valid, r_wb_we, r_wb_hlt;
  logic [REG_AW-1:0] r_wb_rd;

  logic w_freeze, w_halted, w_branch, w_ld_use, w_hlt_accept;
  logic w_pc_hold, w_ifid_flush, w_idex_bubble;

  function automatic logic f_match(input logic [REG_AW-1:0] x, input logic v,
                                   input logic we, input logic [REG_AW-1:0] rd);
    return v && we && (rd == x) && !(ZERO_REG && (x == '0));
  endfunction

  assign w_freeze = (r_frz_cnt != '0);
  assign w_halted = (r_state == S_HALTED);
  assign w_branch = br_taken && !w_freeze && !w_halted;
  assign w_ld_use = id_valid && r_ex_load &&
                    ((id_rs_used && f_match(id_rs, r_ex_valid, r_ex_we, r_ex_rd)) ||
                     (id_rt_used && f_match(id_rt, r_ex_valid, r_ex_we, r_ex_rd)));

  // Priority: halted > load freeze > branch flush > drain / load-use stall
  always_comb begin
    w_pc_hold     = 1'b0;
    w_ifid_flush  = 1'b0;
    w_idex_bubble = 1'b0;
    if (w_halted) begin
      w_pc_hold     = 1'b1;
      w_idex_bubble = 1'b1;
    end else if (w_freeze) begin
      w_pc_hold     = 1'b1;
    end else if (w_branch) begin
      w_ifid_flush  = 1'b1;
      w_idex_bubble = 1'b1;
    end else if ((r_state == S_DRAIN) || w_ld_use) begin
      w_pc_hold     = 1'b1;
      w_idex_bubble = 1'b1;
    end
  end

  assign w_hlt_accept = (r_state == S_RUN) && id_valid && id_hlt && !w_freeze && !w_idex_bubble;

  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (r_ex_valid && r_ex_rs_used) begin
      if (f_match(r_ex_rs, r_mem_valid, r_mem_we, r_mem_rd) && !r_mem_load) fwd_a = 2'b01;
      else if (f_match(r_ex_rs, r_wb_valid, r_wb_we, r_wb_rd))             fwd_a = 2'b10;
    end
    if (r_ex_valid && r_ex_rt_used) begin
      if (f_match(r_ex_rt, r_mem_valid, r_mem_we, r_mem_rd) && !r_mem_load) fwd_b = 2'b01;
      else if (f_match(r_ex_rt, r_wb_valid, r_wb_we, r_wb_rd))             fwd_b = 2'b10;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_RUN;
      r_frz_cnt    <= '0;
      r_hlt        <= 1'b0;
      r_ex_valid   <= 1'b0;
      r_ex_rs      <= '0;
      r_ex_rs_used <= 1'b0;
      r_ex_rt      <= '0;
      r_ex_rt_used <= 1'b0;
      r_ex_rd      <= '0;
      r_ex_we      <= 1'b0;
      r_ex_load    <= 1'b0;
      r_ex_hlt     <= 1'b0;
      r_mem_valid  <= 1'b0;
      r_mem_rd     <= '0;
      r_mem_we     <= 1'b0;
      r_mem_load   <= 1'b0;
      r_mem_hlt    <= 1'b0;
      r_wb_valid   <= 1'b0;
      r_wb_rd      <= '0;
      r_wb_we      <= 1'b0;
      r_wb_hlt     <= 1'b0;
    end else begin
      if (w_halted) begin
        r_ex_valid  <= 1'b0;
        r_mem_valid <= 1'b0;
        r_wb_valid  <= 1'b0;
      end else if (w_freeze) begin
        // Load still waiting on memory: EX and MEM hold, WB sees a bubble
        r_wb_valid <= 1'b0;
        r_frz_cnt  <= r_frz_cnt - CW'(1);
      end else begin
        r_wb_valid   <= r_mem_valid;
        r_wb_rd      <= r_mem_rd;
        r_wb_we      <= r_mem_we;
        r_wb_hlt     <= r_mem_hlt;
        r_mem_valid  <= r_ex_valid;
        r_mem_rd     <= r_ex_rd;
        r_mem_we     <= r_ex_we;
        r_mem_load   <= r_ex_load;
        r_mem_hlt    <= r_ex_hlt;
        r_frz_cnt    <= (r_ex_valid && r_ex_load) ? FRZ_INIT : '0;
        r_ex_valid   <= id_valid && !w_idex_bubble;
        r_ex_rs      <= id_rs;
        r_ex_rs_used <= id_rs_used;
        r_ex_rt      <= id_rt;
        r_ex_rt_used <= id_rt_used;
        r_ex_rd      <= id_rd;
        r_ex_we      <= id_we;
        r_ex_load    <= id_load;
        r_ex_hlt     <= id_hlt;
      end
      case (r_state)
        S_RUN:   if (w_hlt_accept) r_state <= S_DRAIN;
        S_DRAIN: if (r_wb_valid && r_wb_hlt) begin
          r_state <= S_HALTED;
          r_hlt   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign pc_hold     = w_pc_hold;
  assign ifid_flush  = w_ifid_flush;
  assign idex_bubble = w_idex_bubble;
  assign ex_valid    = r_ex_valid;
  assign mem_valid   = r_mem_valid;
  assign wb_valid    = r_wb_valid;
  assign wb_rd       = r_wb_rd;
  assign wb_we       = r_wb_valid && r_wb_we && !(ZERO_REG && (r_wb_rd == '0));
  assign hlt         = r_hlt;

endmodule
